// File: rtl/multiple_transfer_sequencer.sv
// LDM/STM register-list sequencer: walks the latched list lowest register first,
// one register per accepted step, with every output taken straight from a flop.
module multiple_transfer_sequencer #(
    parameter int LIST_WIDTH = 16  // only 16 is supported (4-bit register numbers)
) (
    input  logic                  phi1_clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LIST_WIDTH-1:0] reg_list,
    input  logic                  step,
    input  logic                  abort,
    output logic                  busy,
    output logic                  valid,
    output logic [3:0]            reg_nb_out,
    output logic                  first,
    output logic                  last,
    output logic [3:0]            xfer_index,
    output logic [4:0]            reg_count,
    output logic                  done
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                state_q, state_n;
    logic [LIST_WIDTH-1:0] pending_q, pending_n;
    logic [3:0]            idx_n;
    logic [4:0]            cnt_n;
    logic                  done_n;

    logic                  busy_n, valid_n, first_n, last_n;
    logic [3:0]            nb_n;

    function automatic logic [3:0] lowest_bit(input logic [LIST_WIDTH-1:0] m);
        lowest_bit = '0;
        for (int i = LIST_WIDTH - 1; i >= 0; i--)
            if (m[i]) lowest_bit = 4'(i);
    endfunction

    function automatic logic [4:0] ones(input logic [LIST_WIDTH-1:0] m);
        ones = '0;
        for (int i = 0; i < LIST_WIDTH; i++)
            ones = ones + 5'(m[i]);
    endfunction

    // State and registered outputs
    always_ff @(posedge phi1_clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            reg_nb_out <= '0;
            first      <= 1'b0;
            last       <= 1'b0;
            xfer_index <= '0;
            reg_count  <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_n;
            pending_q  <= pending_n;
            busy       <= busy_n;
            valid      <= valid_n;
            reg_nb_out <= nb_n;
            first      <= first_n;
            last       <= last_n;
            xfer_index <= idx_n;
            reg_count  <= cnt_n;
            done       <= done_n;
        end
    end

    // Next state: abort beats step; start only matters in IDLE
    always_comb begin
        state_n   = state_q;
        pending_n = pending_q;
        idx_n     = xfer_index;
        cnt_n     = reg_count;
        done_n    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_n = ones(reg_list);
                    idx_n = '0;
                    if (reg_list != '0) begin
                        state_n   = SCAN;
                        pending_n = reg_list;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    state_n   = IDLE;
                    pending_n = '0;
                end else if (step) begin
                    // Clearing the lowest set bit retires the current register
                    pending_n = pending_q & (pending_q - LIST_WIDTH'(1));
                    if (xfer_index != 4'hF) idx_n = xfer_index + 4'd1;
                    if (pending_n == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        busy_n  = (state_n == SCAN);
        valid_n = (state_n == SCAN);
        nb_n    = '0;
        first_n = 1'b0;
        last_n  = 1'b0;
        if (state_n == SCAN) begin
            nb_n    = lowest_bit(pending_n);
            first_n = (idx_n == 4'd0);
            last_n  = (pending_n != '0) &&
                      ((pending_n & (pending_n - LIST_WIDTH'(1))) == '0);
        end
    end

endmodule

// File: tb/tb_multiple_transfer_sequencer.sv
// Bench for multiple_transfer_sequencer: directed vector table, full-list walk,
// then random traffic against a queue-based model of the register list.
module tb_multiple_transfer_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] reg_list = '0;
    logic        step = 1'b0;
    logic        abort = 1'b0;
    logic        busy, valid, first, last, done;
    logic [3:0]  reg_nb_out, xfer_index;
    logic [4:0]  reg_count;

    always #5 clk = ~clk;

    multiple_transfer_sequencer #(.LIST_WIDTH(16)) dut (
        .phi1_clock(clk), .reset_n(reset_n), .start(start), .reg_list(reg_list),
        .step(step), .abort(abort), .busy(busy), .valid(valid),
        .reg_nb_out(reg_nb_out), .first(first), .last(last),
        .xfer_index(xfer_index), .reg_count(reg_count), .done(done)
    );

    typedef struct packed {
        logic       busy;
        logic       valid;
        logic [3:0] nb;
        logic       first;
        logic       last;
        logic [3:0] idx;
        logic [4:0] cnt;
        logic       done;
    } out_t;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [15:0] list;
        logic        step;
        logic        abort;
        out_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: the remaining registers as an ordered queue
    bit m_act = 0;
    int m_q[$];
    int m_idx = 0;
    int m_cnt = 0;
    bit m_done = 0;

    function automatic out_t o(logic b, logic v, int nb, logic f, logic l, int idx, int cnt, logic d);
        out_t r;
        r.busy = b; r.valid = v; r.nb = 4'(nb); r.first = f; r.last = l;
        r.idx = 4'(idx); r.cnt = 5'(cnt); r.done = d;
        return r;
    endfunction

    function automatic vec_t vv(logic r, logic s, logic [15:0] l, logic st, logic ab, out_t e);
        vec_t x;
        x.rst_n = r; x.start = s; x.list = l; x.step = st; x.abort = ab; x.exp = e;
        return x;
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic [15:0] l,
                              input logic st, input logic ab);
        if (!r) begin
            m_act = 0; m_q.delete(); m_idx = 0; m_cnt = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (s) begin
                    m_cnt = $countones(l);
                    m_idx = 0;
                    if (l == 16'h0) m_done = 1;
                    else begin
                        m_q.delete();
                        for (int i = 0; i < 16; i++) if (l[i]) m_q.push_back(i);
                        m_act = 1;
                    end
                end
            end else if (ab) begin
                m_act = 0; m_q.delete();
            end else if (st) begin
                void'(m_q.pop_front());
                m_idx = (m_idx < 15) ? m_idx + 1 : 15;
                if (m_q.size() == 0) begin m_act = 0; m_done = 1; end
            end
        end
    endtask

    function automatic out_t model_out();
        out_t e;
        e.busy  = m_act;
        e.valid = m_act;
        e.nb    = m_act ? 4'(m_q[0]) : 4'd0;
        e.first = m_act && (m_idx == 0);
        e.last  = m_act && (m_q.size() == 1);
        e.idx   = 4'(m_idx);
        e.cnt   = 5'(m_cnt);
        e.done  = m_done;
        return e;
    endfunction

    task automatic tick(input logic r, input logic s, input logic [15:0] l,
                        input logic st, input logic ab);
        reset_n = r; start = s; reg_list = l; step = st; abort = ab;
        @(posedge clk);
        model_edge(r, s, l, st, ab);
        cyc++;
        #1;
    endtask

    task automatic check(input string name, input out_t e);
        out_t a;
        a = {busy, valid, reg_nb_out, first, last, xfer_index, reg_count, done};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s cyc=%0d got b=%0b v=%0b nb=%0d f=%0b l=%0b idx=%0d cnt=%0d d=%0b want b=%0b v=%0b nb=%0d f=%0b l=%0b idx=%0d cnt=%0d d=%0b",
                      name, cyc, a.busy, a.valid, a.nb, a.first, a.last, a.idx, a.cnt, a.done,
                      e.busy, e.valid, e.nb, e.first, e.last, e.idx, e.cnt, e.done);
    endtask

    vec_t vecs[27];

    initial begin
        vecs[0]  = vv(0, 0, 16'h0000, 0, 0, o(0,0, 0,0,0,0,0,0));  // reset
        vecs[1]  = vv(1, 1, 16'h8011, 0, 0, o(1,1, 0,1,0,0,3,0));
        vecs[2]  = vv(1, 0, 16'h0000, 1, 0, o(1,1, 4,0,0,1,3,0));
        vecs[3]  = vv(1, 0, 16'h0000, 1, 0, o(1,1,15,0,1,2,3,0));
        vecs[4]  = vv(1, 0, 16'h0000, 1, 0, o(0,0, 0,0,0,3,3,1));
        vecs[5]  = vv(1, 0, 16'h0000, 0, 0, o(0,0, 0,0,0,3,3,0));
        vecs[6]  = vv(1, 1, 16'h0000, 0, 0, o(0,0, 0,0,0,0,0,1));  // empty list
        vecs[7]  = vv(1, 0, 16'h0000, 1, 0, o(0,0, 0,0,0,0,0,0));  // stray step
        vecs[8]  = vv(1, 1, 16'h00F0, 0, 0, o(1,1, 4,1,0,0,4,0));
        vecs[9]  = vv(1, 1, 16'h0001, 0, 0, o(1,1, 4,1,0,0,4,0));  // start while busy
        vecs[10] = vv(1, 0, 16'h0000, 0, 0, o(1,1, 4,1,0,0,4,0));
        vecs[11] = vv(1, 0, 16'h0000, 1, 0, o(1,1, 5,0,0,1,4,0));
        vecs[12] = vv(1, 0, 16'h0000, 1, 0, o(1,1, 6,0,0,2,4,0));
        vecs[13] = vv(1, 0, 16'h0000, 1, 0, o(1,1, 7,0,1,3,4,0));
        vecs[14] = vv(1, 0, 16'h0000, 1, 0, o(0,0, 0,0,0,4,4,1));
        vecs[15] = vv(1, 1, 16'h0F00, 0, 0, o(1,1, 8,1,0,0,4,0));
        vecs[16] = vv(1, 0, 16'h0000, 1, 0, o(1,1, 9,0,0,1,4,0));
        vecs[17] = vv(1, 0, 16'h0000, 1, 1, o(0,0, 0,0,0,1,4,0));  // abort beats step
        vecs[18] = vv(1, 0, 16'h0000, 0, 0, o(0,0, 0,0,0,1,4,0));
        vecs[19] = vv(1, 1, 16'h00E0, 0, 0, o(1,1, 5,1,0,0,3,0));
        vecs[20] = vv(0, 1, 16'h0001, 1, 0, o(0,0, 0,0,0,0,0,0));  // reset mid-transfer
        vecs[21] = vv(1, 0, 16'h0000, 0, 0, o(0,0, 0,0,0,0,0,0));
        vecs[22] = vv(1, 1, 16'h0003, 0, 1, o(1,1, 0,1,0,0,2,0));  // abort in IDLE
        vecs[23] = vv(1, 0, 16'h0000, 1, 0, o(1,1, 1,0,1,1,2,0));
        vecs[24] = vv(1, 0, 16'h0000, 1, 0, o(0,0, 0,0,0,2,2,1));
        vecs[25] = vv(1, 1, 16'h8000, 0, 0, o(1,1,15,1,1,0,1,0));  // single register
        vecs[26] = vv(1, 0, 16'h0000, 1, 0, o(0,0, 0,0,0,1,1,1));

        #2;
        for (int i = 0; i < 27; i++) begin
            tick(vecs[i].rst_n, vecs[i].start, vecs[i].list, vecs[i].step, vecs[i].abort);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Full list with step held high
        tick(1, 1, 16'hFFFF, 0, 0);
        check("full_start", o(1,1,0,1,0,0,16,0));
        for (int i = 1; i < 16; i++) begin
            tick(1, 0, 16'h0000, 1, 0);
            check($sformatf("full_reg%0d", i), o(1,1,i,0,(i == 15),i,16,0));
        end
        tick(1, 0, 16'h0000, 1, 0);
        check("full_done", o(0,0,0,0,0,15,16,1));
        tick(1, 0, 16'h0000, 1, 0);
        check("full_hold", o(0,0,0,0,0,15,16,0));

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic        r, s, st, ab;
            logic [15:0] l;
            int          k;
            r  = ($urandom_range(0, 199) != 0);
            s  = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 1) == 0);
            ab = ($urandom_range(0, 15) == 0);
            k  = $urandom_range(0, 7);
            if (k == 0)      l = 16'h0000;
            else if (k == 1) l = 16'hFFFF;
            else if (k == 2) l = 16'h0001 << $urandom_range(0, 15);
            else             l = 16'($urandom());
            tick(r, s, l, st, ab);
            check("rand", model_out());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
